// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl: sequences machine-mode timer-interrupt entry and mret exit.
// It captures a precise PC from execute and drives the CSR trap strobes, the
// fetch redirect and the pipeline flush.
//
// Handshake: there is no valid/ready pairing here. trap_enter, trap_exit and
// pc_redirect are single-cycle strobes with no backpressure. trap_mepc,
// trap_mcause and pc_target carry data only in the cycle their strobe is high,
// and read as zero in every other cycle. Consumers must act in that cycle.
//
// All outputs are registered. Each output is decoded from the next state at
// the clock edge where that state is entered. As a result:
//   - No input reaches an output combinationally.
//   - The entry target uses the mtvec value from the same edge as ENTER.
//   - The exit target uses the mepc value from the same edge as EXIT.
module csr_trap_ctrl #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] MCAUSE_TIMER = 32'h8000_0007,
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            timer_irq,
    input  logic            mstatus_mie,
    input  logic            mie_mtie,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] pc_ex,
    input  logic            is_mret,
    output logic            trap_enter,
    output logic            trap_exit,
    output logic [XLEN-1:0] trap_mepc,
    output logic [XLEN-1:0] trap_mcause,
    output logic            pc_redirect,
    output logic [XLEN-1:0] pc_target,
    output logic            flush,
    output logic            busy,
    output logic [2:0]      dbg_state,
    output logic            dbg_in_handler
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_VALID = 3'd1,
        ENTER      = 3'd2,
        EXIT       = 3'd3,
        FLUSH      = 3'd4
    } state_t;

    localparam int CNT_W = 8;
    // Extra FLUSH cycles after the ENTER/EXIT cycle, counted down to zero.
    localparam logic [CNT_W-1:0] FLUSH_LOAD =
        (FLUSH_CYCLES > 1) ? CNT_W'(FLUSH_CYCLES - 2) : '0;
    // Vectored offset is the cause code (interrupt bit dropped) shifted left by 2.
    localparam logic [XLEN-1:0] VEC_OFFSET = {MCAUSE_TIMER[XLEN-3:0], 2'b00};

    state_t           state_q, state_d;
    logic             in_handler_q, in_handler_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [XLEN-1:0]  pc_cap_q, pc_cap_d;

    logic             trap_enter_q, trap_enter_d;
    logic             trap_exit_q, trap_exit_d;
    logic [XLEN-1:0]  trap_mepc_q, trap_mepc_d;
    logic [XLEN-1:0]  trap_mcause_q, trap_mcause_d;
    logic             pc_redirect_q, pc_redirect_d;
    logic [XLEN-1:0]  pc_target_q, pc_target_d;
    logic             flush_q, flush_d;
    logic             busy_q, busy_d;

    logic             irq_ok;
    logic [XLEN-1:0]  vec_base;

    assign irq_ok   = timer_irq & mstatus_mie & mie_mtie & ~in_handler_q;
    assign vec_base = {mtvec[XLEN-1:2], 2'b00};

    // Next-state logic and the registered-output decode of that next state.
    always_comb begin
        state_d       = state_q;
        in_handler_d  = in_handler_q;
        flush_cnt_d   = flush_cnt_q;
        pc_cap_d      = pc_cap_q;

        unique case (state_q)
            IDLE: begin
                if (irq_ok && ex_valid) begin
                    pc_cap_d = pc_ex;
                    state_d  = ENTER;
                end else if (irq_ok) begin
                    state_d = WAIT_VALID;
                end else if (ex_valid && is_mret && in_handler_q) begin
                    state_d = EXIT;
                end
            end
            WAIT_VALID: begin
                if (!irq_ok) begin
                    state_d = IDLE;
                end else if (ex_valid) begin
                    pc_cap_d = pc_ex;
                    state_d  = ENTER;
                end
            end
            ENTER, EXIT: begin
                in_handler_d = (state_q == ENTER);
                flush_cnt_d  = FLUSH_LOAD;
                state_d      = (FLUSH_CYCLES > 1) ? FLUSH : IDLE;
            end
            FLUSH: begin
                if (flush_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        trap_enter_d  = (state_d == ENTER);
        trap_exit_d   = (state_d == EXIT);
        pc_redirect_d = (state_d == ENTER) || (state_d == EXIT);
        flush_d       = (state_d == ENTER) || (state_d == EXIT) || (state_d == FLUSH);
        busy_d        = (state_d != IDLE);
        trap_mepc_d   = (state_d == ENTER) ? pc_cap_d : '0;
        trap_mcause_d = (state_d == ENTER) ? MCAUSE_TIMER : '0;
        pc_target_d   = '0;
        if (state_d == ENTER) begin
            pc_target_d = (mtvec[1:0] == 2'b01) ? (vec_base + VEC_OFFSET) : vec_base;
        end else if (state_d == EXIT) begin
            pc_target_d = mepc;
        end
    end

    // State, handler flag, counter, PC capture and output registers.
    // Reset wins over every event in every state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            in_handler_q  <= 1'b0;
            flush_cnt_q   <= '0;
            pc_cap_q      <= '0;
            trap_enter_q  <= 1'b0;
            trap_exit_q   <= 1'b0;
            trap_mepc_q   <= '0;
            trap_mcause_q <= '0;
            pc_redirect_q <= 1'b0;
            pc_target_q   <= '0;
            flush_q       <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            in_handler_q  <= in_handler_d;
            flush_cnt_q   <= flush_cnt_d;
            pc_cap_q      <= pc_cap_d;
            trap_enter_q  <= trap_enter_d;
            trap_exit_q   <= trap_exit_d;
            trap_mepc_q   <= trap_mepc_d;
            trap_mcause_q <= trap_mcause_d;
            pc_redirect_q <= pc_redirect_d;
            pc_target_q   <= pc_target_d;
            flush_q       <= flush_d;
            busy_q        <= busy_d;
        end
    end

    assign trap_enter     = trap_enter_q;
    assign trap_exit      = trap_exit_q;
    assign trap_mepc      = trap_mepc_q;
    assign trap_mcause    = trap_mcause_q;
    assign pc_redirect    = pc_redirect_q;
    assign pc_target      = pc_target_q;
    assign flush          = flush_q;
    assign busy           = busy_q;
    assign dbg_state      = state_q;
    assign dbg_in_handler = in_handler_q;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed bench for csr_trap_ctrl. Inputs change 1ns after a rising edge.
// Outputs are sampled at that same point, so they show the edge just taken.
module tb_csr_trap_ctrl;

  localparam logic [31:0] MCAUSE = 32'h8000_0007;
  localparam logic [2:0]  S_IDLE = 3'd0;
  localparam logic [2:0]  S_WAIT = 3'd1;
  localparam logic [2:0]  S_ENTR = 3'd2;
  localparam logic [2:0]  S_EXIT = 3'd3;
  localparam logic [2:0]  S_FLSH = 3'd4;

  logic        clk = 1'b0;
  logic        reset;
  logic        timer_irq, mstatus_mie, mie_mtie, ex_valid, is_mret;
  logic [31:0] mtvec, mepc, pc_ex;
  logic        trap_enter, trap_exit, pc_redirect, flush, busy, dbg_in_handler;
  logic [31:0] trap_mepc, trap_mcause, pc_target;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // clock / reset block
  always #5 clk = ~clk;

  csr_trap_ctrl dut (
    .clk(clk), .reset(reset), .timer_irq(timer_irq), .mstatus_mie(mstatus_mie),
    .mie_mtie(mie_mtie), .mtvec(mtvec), .mepc(mepc), .ex_valid(ex_valid),
    .pc_ex(pc_ex), .is_mret(is_mret), .trap_enter(trap_enter), .trap_exit(trap_exit),
    .trap_mepc(trap_mepc), .trap_mcause(trap_mcause), .pc_redirect(pc_redirect),
    .pc_target(pc_target), .flush(flush), .busy(busy), .dbg_state(dbg_state),
    .dbg_in_handler(dbg_in_handler)
  );

  // scoreboard compare
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare the 1-bit controls and the debug state in one go.
  task automatic check_ctl(input string tag, input logic te, input logic tx,
                           input logic pr, input logic fl, input logic bz,
                           input logic [2:0] st);
    check({tag, ".trap_enter"},  {31'd0, trap_enter},  {31'd0, te});
    check({tag, ".trap_exit"},   {31'd0, trap_exit},   {31'd0, tx});
    check({tag, ".pc_redirect"}, {31'd0, pc_redirect}, {31'd0, pr});
    check({tag, ".flush"},       {31'd0, flush},       {31'd0, fl});
    check({tag, ".busy"},        {31'd0, busy},        {31'd0, bz});
    check({tag, ".state"},       {29'd0, dbg_state},   {29'd0, st});
  endtask

  // Driver tasks
  task automatic idle_inputs();
    timer_irq = 1'b0; ex_valid = 1'b0; is_mret = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    mstatus_mie = 1'b1; mie_mtie = 1'b1;
    mtvec = 32'h100; mepc = 32'h0; pc_ex = 32'h0;
    tick(); tick();
    reset = 1'b0;
  endtask

  // Drop the request, present mret, and walk EXIT -> FLUSH -> IDLE.
  task automatic do_mret(input string tag, input logic [31:0] ret_pc);
    idle_inputs();
    mepc = ret_pc; ex_valid = 1'b1; is_mret = 1'b1; pc_ex = 32'h300;
    tick();
    check_ctl({tag, ".exit"}, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, S_EXIT);
    check({tag, ".exit_target"}, pc_target, ret_pc);
    idle_inputs();
    tick();
    check_ctl({tag, ".exit_flush"}, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, S_FLSH);
    tick();
    check_ctl({tag, ".exit_idle"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE);
    check({tag, ".in_handler_clr"}, {31'd0, dbg_in_handler}, 32'd0);
  endtask

  initial begin
    do_reset();
    check_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE);
    check("reset.pc_target", pc_target, 32'h0);
    check("reset.trap_mcause", trap_mcause, 32'h0);
    check("reset.in_handler", {31'd0, dbg_in_handler}, 32'd0);

    // 1. Direct entry, then 5. round trip
    timer_irq = 1'b1; ex_valid = 1'b1; pc_ex = 32'h40; mtvec = 32'h100;
    tick();
    check_ctl("entry", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, S_ENTR);
    check("entry.pc_target", pc_target, 32'h100);
    check("entry.trap_mepc", trap_mepc, 32'h40);
    check("entry.trap_mcause", trap_mcause, MCAUSE);
    idle_inputs();
    tick();
    check_ctl("entry.flush2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, S_FLSH);
    check("entry.in_handler", {31'd0, dbg_in_handler}, 32'd1);
    tick();
    check_ctl("entry.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE);
    // While inside the handler, a second request is masked.
    timer_irq = 1'b1; ex_valid = 1'b1;
    tick();
    check_ctl("nested_masked", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE);
    do_mret("rt", 32'h40);

    // 2. Vectored entry
    mtvec = 32'h101; timer_irq = 1'b1; ex_valid = 1'b1; pc_ex = 32'h44;
    tick();
    check_ctl("vec", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, S_ENTR);
    check("vec.pc_target", pc_target, 32'h11C);
    tick(); tick();
    do_mret("vec", 32'h44);
    mtvec = 32'h100;

    // 3. Bubble: wait for a valid instruction
    timer_irq = 1'b1; ex_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_ctl("bubble.wait", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, S_WAIT);
    end
    ex_valid = 1'b1; pc_ex = 32'h88;
    tick();
    check_ctl("bubble.enter", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, S_ENTR);
    check("bubble.trap_mepc", trap_mepc, 32'h88);
    tick(); tick();
    do_mret("bubble", 32'h88);

    // 3b. Request drops during the wait
    timer_irq = 1'b1; ex_valid = 1'b0;
    tick();
    check_ctl("drop.wait", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, S_WAIT);
    timer_irq = 1'b0;
    tick();
    check_ctl("drop.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE);
    tick();
    check_ctl("drop.quiet", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE);

    // 4. Masking and a stray mret
    mstatus_mie = 1'b0; timer_irq = 1'b1; ex_valid = 1'b1;
    tick(); tick();
    check_ctl("mask.mie", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE);
    mstatus_mie = 1'b1; mie_mtie = 1'b0;
    tick(); tick();
    check_ctl("mask.mtie", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE);
    mie_mtie = 1'b1; timer_irq = 1'b0; is_mret = 1'b1; mepc = 32'h500;
    tick();
    check_ctl("stray_mret", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE);
    check("stray_mret.pc_target", pc_target, 32'h0);
    idle_inputs();

    // 5b. Interrupt and mret in the same cycle: entry wins
    timer_irq = 1'b1; ex_valid = 1'b1; is_mret = 1'b1; pc_ex = 32'h200;
    tick();
    check_ctl("prio", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, S_ENTR);
    check("prio.trap_mepc", trap_mepc, 32'h200);
    idle_inputs();

    // 6. Reset while in ENTER (the current state)
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_ctl("rst_enter", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE);
    check("rst_enter.in_handler", {31'd0, dbg_in_handler}, 32'd0);
    check("rst_enter.trap_mepc", trap_mepc, 32'h0);

    // 6b. Reset while in FLUSH
    timer_irq = 1'b1; ex_valid = 1'b1; pc_ex = 32'h60;
    tick();
    idle_inputs();
    tick();
    check_ctl("pre_rst_flush", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, S_FLSH);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_ctl("rst_flush", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_IDLE);
    check("rst_flush.in_handler", {31'd0, dbg_in_handler}, 32'd0);
    check("rst_flush.pc_target", pc_target, 32'h0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
